// File: rtl/mio_bus_responder.sv
// Memory/IO bus responder: decodes CPU MemRead/MemWrite requests to an internal word RAM or an
// external IO port, inserts wait states and returns a one-cycle mio_ready (and err) pulse.
module mio_bus_responder #(
    parameter int unsigned DEPTH_LOG2 = 10,
    parameter int unsigned RD_WAIT    = 2,
    parameter int unsigned WR_WAIT    = 1,
    parameter int unsigned IO_TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        mio_ready,
    output logic        err,
    output logic        io_rd,
    output logic        io_wr,
    output logic [7:0]  io_addr,
    output logic [31:0] io_wdata,
    input  logic [31:0] io_rdata,
    input  logic        io_ack
);

    typedef enum logic [1:0] {StIdle, StWait, StIoWait, StAck} state_e;

    state_e                state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic                  op_wr_q, op_wr_d;
    logic                  flag_q, flag_d;
    logic [DEPTH_LOG2-1:0] idx_q, idx_d;
    logic [31:0]           wdata_q, wdata_d;
    logic [31:0]           rdata_q, rdata_d;
    logic                  mio_ready_q, mio_ready_d;
    logic                  err_q, err_d;
    logic                  io_rd_q, io_rd_d;
    logic                  io_wr_q, io_wr_d;
    logic [7:0]            io_addr_q, io_addr_d;
    logic [31:0]           io_wdata_q, io_wdata_d;
    logic                  ram_we;

    logic [31:0] mem [2**DEPTH_LOG2];

    // Upper address bits below bit 31 are deliberately ignored (RAM aliasing).
    logic unused_addr;
    assign unused_addr = ^addr[30:DEPTH_LOG2+2];

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        op_wr_d     = op_wr_q;
        flag_d      = flag_q;
        idx_d       = idx_q;
        wdata_d     = wdata_q;
        rdata_d     = rdata_q;
        io_rd_d     = io_rd_q;
        io_wr_d     = io_wr_q;
        io_addr_d   = io_addr_q;
        io_wdata_d  = io_wdata_q;
        ram_we      = 1'b0;
        mio_ready_d = (state_q == StAck);
        err_d       = (state_q == StAck) && flag_q;

        unique case (state_q)
            StIdle: begin
                if (mem_read || mem_write) begin
                    op_wr_d = mem_write;
                    idx_d   = addr[DEPTH_LOG2+1:2];
                    wdata_d = wdata;
                    flag_d  = 1'b0;
                    if ((mem_read && mem_write) || (addr[1:0] != 2'b00)) begin
                        flag_d  = 1'b1;
                        state_d = StAck;
                    end else if (!addr[31]) begin
                        state_d = StWait;
                        cnt_d   = mem_write ? 4'(WR_WAIT) : 4'(RD_WAIT);
                    end else begin
                        state_d    = StIoWait;
                        io_rd_d    = mem_read;
                        io_wr_d    = mem_write;
                        io_addr_d  = addr[9:2];
                        io_wdata_d = wdata;
                        cnt_d      = 4'(IO_TIMEOUT);
                    end
                end
            end
            StWait: begin
                if (cnt_q == 4'd0) begin
                    state_d = StAck;
                    if (op_wr_q) ram_we = 1'b1;
                    else         rdata_d = mem[idx_q];
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StIoWait: begin
                if (io_ack) begin
                    io_rd_d = 1'b0;
                    io_wr_d = 1'b0;
                    state_d = StAck;
                    if (!op_wr_q) rdata_d = io_rdata;
                end else if (cnt_q == 4'd0) begin
                    io_rd_d = 1'b0;
                    io_wr_d = 1'b0;
                    flag_d  = 1'b1;
                    state_d = StAck;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StAck: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            cnt_q       <= 4'd0;
            op_wr_q     <= 1'b0;
            flag_q      <= 1'b0;
            idx_q       <= '0;
            wdata_q     <= 32'd0;
            rdata_q     <= 32'd0;
            mio_ready_q <= 1'b0;
            err_q       <= 1'b0;
            io_rd_q     <= 1'b0;
            io_wr_q     <= 1'b0;
            io_addr_q   <= 8'd0;
            io_wdata_q  <= 32'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            op_wr_q     <= op_wr_d;
            flag_q      <= flag_d;
            idx_q       <= idx_d;
            wdata_q     <= wdata_d;
            rdata_q     <= rdata_d;
            mio_ready_q <= mio_ready_d;
            err_q       <= err_d;
            io_rd_q     <= io_rd_d;
            io_wr_q     <= io_wr_d;
            io_addr_q   <= io_addr_d;
            io_wdata_q  <= io_wdata_d;
        end
    end

    // RAM contents are not reset; ram_we is gated by the state, so reset suppresses commits.
    always_ff @(posedge clk) begin
        if (ram_we) mem[idx_q] <= wdata_q;
    end

    assign rdata     = rdata_q;
    assign mio_ready = mio_ready_q;
    assign err       = err_q;
    assign io_rd     = io_rd_q;
    assign io_wr     = io_wr_q;
    assign io_addr   = io_addr_q;
    assign io_wdata  = io_wdata_q;

endmodule
